// File: rtl/gf_inv_sbox_iter.sv
// AES inverse S-box, one byte at a time: inverse affine, then x^254 by 7 square-and-multiply steps in GF(2^8) mod 0x11B.
// Optional macro GF_INV_SBOX_FWD_EN adds a fwd input that selects the forward S-box through the same engine.
module gf_inv_sbox_iter (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef GF_INV_SBOX_FWD_EN
  ,
  input  logic       fwd
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [7:0] s, r;
  logic [7:0] t, rt, res, s_load;
`ifdef GF_INV_SBOX_FWD_EN
  logic       fwd_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // rotl(x,1) ^ rotl(x,3) ^ rotl(x,6) ^ 0x05
  function automatic logic [7:0] invaff(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

`ifdef GF_INV_SBOX_FWD_EN
  function automatic logic [7:0] fwdaff(input logic [7:0] y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction
`endif

  always_comb begin
    t      = gf_mul8(s, s);
    rt     = gf_mul8(r, t);
    res    = rt;
    s_load = invaff(in_data);
`ifdef GF_INV_SBOX_FWD_EN
    if (fwd_q) res = fwdaff(rt);
    if (fwd)   s_load = in_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == 3'd6) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // After the seventh step r holds s0^(2+4+...+128) = s0^254; zero stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 8'h00;
      r        <= 8'h01;
      cnt      <= 3'd0;
      out_data <= 8'h00;
`ifdef GF_INV_SBOX_FWD_EN
      fwd_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s   <= s_load;
          r   <= 8'h01;
          cnt <= 3'd0;
`ifdef GF_INV_SBOX_FWD_EN
          fwd_q <= fwd;
`endif
        end
        RUN: begin
          s   <= t;
          r   <= rt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            cnt      <= 3'd0;
            out_data <= res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inv_sbox_iter.sv
// Directed bench for gf_inv_sbox_iter: latency, corners, back-pressure, reset abort, back-to-back, full table sweep.
module tb_gf_inv_sbox_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef GF_INV_SBOX_FWD_EN
  logic       fwd;
`endif

  int checks   = 0;
  int failures = 0;

  logic [0:255][7:0] sbox_tab;

  always #5 clk = ~clk;

  gf_inv_sbox_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef GF_INV_SBOX_FWD_EN
    ,
    .fwd       (fwd)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE with out_ready high; checks latency and result.
  task automatic xfer(input logic [7:0] din, input logic [7:0] exp, input string tag);
    int n;
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chkn({tag, "_lat"}, n, 7);
    chk8({tag, "_dat"}, out_data, exp);
    step();
  endtask

  logic [7:0] b2b_in  [3];
  logic [7:0] b2b_exp [3];
  int         acc_t   [3];

  initial begin
    int n;
    int k;
    int got;
    sbox_tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hED;
    out_ready = 1'b1;
`ifdef GF_INV_SBOX_FWD_EN
    fwd = 1'b0;
`endif
    step();
    step();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_data", out_data, 8'h00);
    chkn("rst_cnt", int'(dut.cnt), 0);
    chk8("rst_s", dut.s, 8'h00);
    chk8("rst_r", dut.r, 8'h01);
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    chk1("idle_no_accept", busy, 1'b0);

    // Detailed timing of the first transaction.
    in_data  = 8'hED;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk1("run_in_ready", in_ready, 1'b0);
    chk1("run_busy", busy, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      in_data = 8'hAA;
      step();
      n++;
    end
    chkn("ed_latency", n, 7);
    chk8("ed_data", out_data, 8'h53);
    chk1("done_in_ready", in_ready, 1'b0);
    chk1("done_busy", busy, 1'b1);
    step();
    chk1("pulse_end", out_valid, 1'b0);
    chk1("ready_back", in_ready, 1'b1);
    chk1("busy_clear", busy, 1'b0);
    chk8("data_kept", out_data, 8'h53);

    xfer(8'h63, 8'h00, "c63");
    xfer(8'h00, 8'h52, "c00");
    xfer(8'h16, 8'hFF, "c16");

    // Back-pressure in DONE with a stray in_valid.
    in_data   = 8'hED;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chkn("bp_latency", n, 7);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", out_valid, 1'b1);
      chk8("bp_data", out_data, 8'h53);
      chk1("bp_in_ready", in_ready, 1'b0);
      in_valid = (i == 2);
      in_data  = 8'h7C;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk1("bp_still_valid", out_valid, 1'b1);
    step();
    chk1("bp_released", out_valid, 1'b0);
    chk1("bp_idle", in_ready, 1'b1);
    chk8("bp_data_kept", out_data, 8'h53);
    step();
    chk1("bp_stray_ignored", busy, 1'b0);

    // Reset on the 4th RUN cycle aborts the byte.
    in_data  = 8'h16;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk8("abort_out_data", out_data, 8'h00);
    chk1("abort_busy", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) n++;
      step();
    end
    chkn("abort_no_pulse", n, 0);
    xfer(8'h7C, 8'h01, "c7c");

    // Back-to-back with in_valid held and in_data scrambled mid-RUN.
    b2b_in  = '{8'hED, 8'h7C, 8'h16};
    b2b_exp = '{8'h53, 8'h01, 8'hFF};
    k   = 0;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (in_ready) begin
        if (k < 3) begin
          in_data  = b2b_in[k];
          in_valid = 1'b1;
          acc_t[k] = c;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end else if (!out_valid) begin
        in_data = 8'($urandom);
      end
      if (out_valid) begin
        chk8("b2b_data", out_data, b2b_exp[got]);
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    chkn("b2b_count", got, 3);
    chkn("b2b_gap1", acc_t[1] - acc_t[0], 9);
    chkn("b2b_gap2", acc_t[2] - acc_t[1], 9);
    step();

    // Full sweep: InvSBox(SBox(x)) must give back x for every x.
    for (int x = 0; x < 256; x++) begin
      xfer(sbox_tab[x], 8'(x), "sweep");
    end

`ifdef GF_INV_SBOX_FWD_EN
    fwd = 1'b1;
    xfer(8'h53, 8'hED, "fwd53");
    xfer(8'h00, 8'h63, "fwd00");
    fwd = 1'b0;
    xfer(8'hED, 8'h53, "invED");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
